fifo_sync_param: RTL and testbench



---
 rtl/fifo_sync_param.sv | 164 ++++++++++++++++
 tb/tb_fifo_sync_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//
// Single-clock parametrised FIFO: storage array, binary read/write pointers,
// registered occupancy counter and status flags in one block. The read side
// works in one of two modes:
//   FWFT = 0 : registered read, rdata/rvalid appear one clock after an
//              accepted rinc and rdata holds its value otherwise.
//   FWFT = 1 : first-word-fall-through, the head word is always presented on
//              rdata and rvalid simply mirrors "not empty".
//
// Ports
//   clk           : clock, all logic on posedge
//   rst_n         : synchronous reset, active low
//   winc, wdata   : write request and data
//   rinc          : read request (FWFT: pop the head word)
//   clr_err       : clears the sticky overflow/underflow flags
//   rdata, rvalid : read data and its qualifier
//   wfull, rempty : count == DEPTH / count == 0
//   walmost_full  : count >= AFULL_THRESH
//   ralmost_empty : count <= AEMPTY_THRESH
//   count         : occupancy 0..DEPTH
//   overflow      : sticky, write attempted while full
//   underflow     : sticky, read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    input  logic                clr_err,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam int CW    = ADDRSIZE + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [DATASIZE-1:0] mem [DEPTH];

    logic [CW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          wa;
    logic          ra;

    // Flags are pure decodes of the registered count, so they can never see
    // winc/rinc combinationally and always lag the causing edge by one cycle.
    assign wfull         = (count_q == DEPTH_C);
    assign rempty        = (count_q == '0);
    assign walmost_full  = (count_q >= AFULL_C);
    assign ralmost_empty = (count_q <= AEMPTY_C);
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    // A full FIFO rejects the write even when a read is accepted in the same
    // cycle; an empty FIFO likewise rejects the read of a simultaneous write.
    assign wa = winc & ~wfull;
    assign ra = rinc & ~rempty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q + CW'(wa) - CW'(ra);
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wa) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (ra) begin
            rptr_d = rptr_q + 1'b1;
        end

        // Clear first, then set, so a coincident error event wins over clr_err.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (winc && wfull) begin
            overflow_d = 1'b1;
        end
        if (rinc && rempty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; stale contents are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && wa) begin
            mem[wptr_q[ADDRSIZE-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT == 0) begin : gen_reg_read
            logic [DATASIZE-1:0] rdata_q;
            logic                rvalid_q;
            logic                rvalid_d;

            assign rvalid_d = ra;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rvalid_d;
                    if (ra) begin
                        rdata_q <= mem[rptr_q[ADDRSIZE-1:0]];
                    end
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end else begin : gen_fwft_read
            // Head word is always on the bus; a write into an empty FIFO shows
            // up the cycle after its write edge because count gates rvalid.
            assign rdata  = mem[rptr_q[ADDRSIZE-1:0]];
            assign rvalid = ~rempty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
//
// Two instances share one stimulus stream: u_reg (FWFT=0) and u_fwft (FWFT=1).
// A queue-based model tracks the FIFO contents and sticky errors; a negedge
// process compares both instances with it each cycle, and the directed
// sequence adds literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 14;
    localparam int AEMPTY = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          rinc;
    logic          clr_err;

    logic [DW-1:0] rdata0, rdata1;
    logic          rvalid0, rvalid1;
    logic          wfull0, wfull1, rempty0, rempty1;
    logic          afull0, afull1, aempty0, aempty1;
    logic [AW:0]   count0, count1;
    logic          ovf0, ovf1, unf0, unf1;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(0),
                      .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)) u_reg (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
        .clr_err(clr_err), .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0),
        .rempty(rempty0), .walmost_full(afull0), .ralmost_empty(aempty0),
        .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    fifo_sync_param #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(1),
                      .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)) u_fwft (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
        .clr_err(clr_err), .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1),
        .rempty(rempty1), .walmost_full(afull1), .ralmost_empty(aempty1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic          m_rvalid0 = 1'b0;
    logic [DW-1:0] m_rdata0 = '0;

    always @(posedge clk) begin
        int  sz;
        bit  full, empty;
        sz    = q.size();
        full  = (sz == DEPTH);
        empty = (sz == 0);
        if (!rst_n) begin
            q.delete();
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
            m_rvalid0 = 1'b0;
            m_rdata0  = '0;
        end else begin
            if (clr_err) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (winc && full)  m_ovf = 1'b1;
            if (rinc && empty) m_unf = 1'b1;
            m_rvalid0 = 1'b0;
            if (rinc && !empty) begin
                m_rdata0  = q.pop_front();
                m_rvalid0 = 1'b1;
                $display("read  0x%02h  occupancy %0d", m_rdata0, q.size());
            end
            if (winc && !full) begin
                q.push_back(wdata);
                $display("write 0x%02h  occupancy %0d", wdata, q.size());
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking) begin
            int sz;
            sz = q.size();
            chk("count_reg",   32'(count0),  32'(sz));
            chk("count_fwft",  32'(count1),  32'(sz));
            chk("wfull_reg",   32'(wfull0),  32'(sz == DEPTH));
            chk("wfull_fwft",  32'(wfull1),  32'(sz == DEPTH));
            chk("rempty_reg",  32'(rempty0), 32'(sz == 0));
            chk("rempty_fwft", 32'(rempty1), 32'(sz == 0));
            chk("afull_reg",   32'(afull0),  32'(sz >= AFULL));
            chk("afull_fwft",  32'(afull1),  32'(sz >= AFULL));
            chk("aempty_reg",  32'(aempty0), 32'(sz <= AEMPTY));
            chk("aempty_fwft", 32'(aempty1), 32'(sz <= AEMPTY));
            chk("ovf_reg",     32'(ovf0),    32'(m_ovf));
            chk("ovf_fwft",    32'(ovf1),    32'(m_ovf));
            chk("unf_reg",     32'(unf0),    32'(m_unf));
            chk("unf_fwft",    32'(unf1),    32'(m_unf));
            chk("rvalid_reg",  32'(rvalid0), 32'(m_rvalid0));
            chk("rdata_reg",   32'(rdata0),  32'(m_rdata0));
            chk("rvalid_fwft", 32'(rvalid1), 32'(sz != 0));
            if (sz != 0) begin
                chk("rdata_fwft", 32'(rdata1), 32'(q[0]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        @(negedge clk);
        winc    = w;
        wdata   = d;
        rinc    = r;
        clr_err = c;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; winc = 1'b0; wdata = '0; rinc = 1'b0; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        // reset defaults
        chk("rst_count",  32'(count0),  32'd0);
        chk("rst_rempty", 32'(rempty0), 32'd1);
        chk("rst_wfull",  32'(wfull0),  32'd0);
        chk("rst_aempty", 32'(aempty0), 32'd1);
        chk("rst_afull",  32'(afull0),  32'd0);
        chk("rst_rvalid", 32'(rvalid0), 32'd0);
        chk("rst_rdata",  32'(rdata0),  32'h00);
        rst_n = 1'b1;
        checking = 1'b1;

        // fill 0x00..0x0F then one rejected write
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        idle();
        chk("fill_count", 32'(count0), 32'd16);
        chk("fill_wfull", 32'(wfull0), 32'd1);
        chk("fill_afull", 32'(afull0), 32'd1);
        chk("fill_ovf",   32'(ovf0),   32'd1);
        idle();
        idle();
        chk("ovf_held", 32'(ovf0), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        chk("ovf_clr", 32'(ovf0), 32'd0);

        // ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            if (i >= 1) begin
                chk("drain_rdata",  32'(rdata0),  32'(i - 1));
                chk("drain_rvalid", 32'(rvalid0), 32'd1);
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);   // extra read on an empty FIFO
        chk("drain_last", 32'(rdata0), 32'h0F);
        idle();
        chk("unf_set",     32'(unf0),    32'd1);
        chk("unf_rvalid",  32'(rvalid0), 32'd0);
        chk("unf_rdata",   32'(rdata0),  32'h0F);
        chk("unf_rempty",  32'(rempty0), 32'd1);

        // underflow set coinciding with clr_err: set wins
        step(1'b0, 8'h00, 1'b1, 1'b1);
        idle();
        chk("set_wins", 32'(unf0), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        chk("unf_clr", 32'(unf0), 32'd0);

        // simultaneous read/write at count 8, pointers wrap
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'(8'h90 + k), 1'b1, 1'b0);
            chk("rw_count", 32'(count0), 32'd8);
        end
        for (int k = 0; k < 8; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("rw_last",  32'(rdata0), 32'hA3);
        chk("rw_empty", 32'(count0), 32'd0);

        // FWFT presentation
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        idle();
        chk("fwft_rvalid", 32'(rvalid1), 32'd1);
        chk("fwft_rdata",  32'(rdata1),  32'h5C);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("fwft_rempty", 32'(rempty1), 32'd1);
        chk("fwft_novalid", 32'(rvalid1), 32'd0);

        // reset mid-operation at count 5, requests ignored during reset
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
        idle();
        chk("pre_rst_count", 32'(count1), 32'd5);
        @(negedge clk);
        rst_n = 1'b0; winc = 1'b1; wdata = 8'h77; rinc = 1'b1; clr_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; winc = 1'b0; rinc = 1'b0;
        chk("mid_rst_count",  32'(count1),  32'd0);
        chk("mid_rst_rempty", 32'(rempty1), 32'd1);
        chk("mid_rst_rdata",  32'(rdata0),  32'h00);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        idle();
        chk("post_rst_fwft", 32'(rdata1), 32'h33);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        chk("post_rst_reg",    32'(rdata0),  32'h33);
        chk("post_rst_rvalid", 32'(rvalid0), 32'd1);

        repeat (3) idle();
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
